// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_pkg                                                               |
// | Opcode encodings and FSM state type shared by seq_alu and its bench.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package alu_pkg;

   localparam logic [3:0] OP_LD   = 4'b0000;
   localparam logic [3:0] OP_MOV  = 4'b0001;
   localparam logic [3:0] OP_SHL  = 4'b0100;
   localparam logic [3:0] OP_SHR  = 4'b0101;
   localparam logic [3:0] OP_ADD  = 4'b0110;
   localparam logic [3:0] OP_ADC  = 4'b0111;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SBC  = 4'b1001;
   localparam logic [3:0] OP_BEQ  = 4'b1010;
   localparam logic [3:0] OP_BT   = 4'b1011;
   localparam logic [3:0] OP_GT   = 4'b1100;
   localparam logic [3:0] OP_FBIT = 4'b1101;
   localparam logic [3:0] OP_LBIT = 4'b1110;
   localparam logic [3:0] OP_MUL  = 4'b1111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MRUN = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_serial.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_mul_serial                                                        |
// | Unsigned shift-add multiplier, one multiplier bit per clock.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module alu_mul_serial #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic                 run_q, run_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   prod_step;
   logic                 last_step;

   always_comb begin
      prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
      last_step = run_q && (cnt_q == CNT_W'(WIDTH - 1));
      run_d     = run_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      mplier_d  = mplier_q;
      if (start) begin
         run_d    = 1'b1;
         cnt_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         prod_d   = '0;
      end else if (run_q) begin
         prod_d   = prod_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (last_step) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q    <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
      end else begin
         run_q    <= run_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
      end
   end

   // Product is presented combinationally so the final add lands in the same edge as done.
   assign done    = last_step;
   assign product = prod_step;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seq_alu                                                               |
// | Registered accumulator ALU, one-cycle ops plus optional serial MUL.   |
// | Optional feature macro: SEQ_ALU_MUL_EN                                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] Input,
   input  logic [WIDTH-1:0] Acc,
   output logic [WIDTH-1:0] Out,
   output logic             Zero,
   output logic             Cout,
   output logic             Busy,
   output logic             Done
);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     out_q, out_d;
   logic                 zero_q, zero_d;
   logic                 cout_q, cout_d;
   logic                 done_q, done_d;
   logic [WIDTH:0]       op_sum, op_diff;
   logic [WIDTH-1:0]     op_res;
   logic                 op_cout;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_prod;

`ifdef SEQ_ALU_MUL_EN
   localparam logic MUL_EN = 1'b1;
   logic mul_start;

   assign mul_start = Start && (state_q == ST_IDLE) && (Op == OP_MUL);

   alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
      .clk     (Clk),
      .rst     (Reset),
      .start   (mul_start),
      .a       (Input),
      .b       (Acc),
      .done    (mul_done),
      .product (mul_prod)
   );

   assign Busy = (state_q == ST_MRUN);
`else
   localparam logic MUL_EN = 1'b0;

   assign mul_done = 1'b0;
   assign mul_prod = '0;
   assign Busy     = 1'b0;
`endif

   // Carry-in only participates for ADC/SBC; WIDTH+1 bits expose carry and borrow.
   always_comb begin
      op_sum  = {1'b0, Input} + {1'b0, Acc} + {{WIDTH{1'b0}}, (Op == OP_ADC) & cout_q};
      op_diff = {1'b0, Input} - {1'b0, Acc} - {{WIDTH{1'b0}}, (Op == OP_SBC) & cout_q};
      op_res  = '0;
      op_cout = cout_q;
      case (Op)
         OP_LD:           op_res = Input;
         OP_MOV:          op_res = Acc;
         OP_SHL:          op_res = Input << 1;
         OP_SHR:          op_res = Input >> 1;
         OP_ADD, OP_ADC: begin
            op_res  = op_sum[WIDTH-1:0];
            op_cout = op_sum[WIDTH];
         end
         OP_SUB, OP_SBC: begin
            op_res  = op_diff[WIDTH-1:0];
            op_cout = op_diff[WIDTH];
         end
         OP_BEQ, OP_BT:   op_res = Acc;
         OP_GT:           op_res = {{(WIDTH-1){1'b0}}, (Acc < Input)};
         OP_FBIT:         op_res = {{(WIDTH-1){1'b0}}, Input[0]};
         OP_LBIT:         op_res = {{(WIDTH-1){1'b0}}, Input[WIDTH-1]};
         default:         op_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      zero_d  = zero_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               if (MUL_EN && (Op == OP_MUL)) begin
                  state_d = ST_MRUN;
               end else begin
                  out_d  = op_res;
                  zero_d = (op_res == '0);
                  cout_d = op_cout;
                  done_d = 1'b1;
               end
            end
         end
         ST_MRUN: begin
            if (mul_done) begin
               state_d = ST_IDLE;
               out_d   = mul_prod[WIDTH-1:0];
               zero_d  = (mul_prod[WIDTH-1:0] == '0);
               cout_d  = |mul_prod[2*WIDTH-1:WIDTH];
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         out_q   <= '0;
         zero_q  <= 1'b1;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         zero_q  <= zero_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign Out  = out_q;
   assign Zero = zero_q;
   assign Cout = cout_q;
   assign Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_seq_alu                                                            |
// | Randomized self-checking bench for seq_alu against an arithmetic model.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_seq_alu;
   import alu_pkg::*;

   localparam int W   = 8;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   op = 4'h0;
   logic [W-1:0] in_v = '0;
   logic [W-1:0] acc_v = '0;
   logic [W-1:0] out_v;
   logic         zero_v, cout_v, busy_v, done_v;

   int n_checks = 0;
   int n_errors = 0;
   int m_out  = 0;
   int m_cout = 0;

   seq_alu #(.WIDTH(W)) dut (
      .Clk   (clk),
      .Reset (rst),
      .Start (start),
      .Op    (op),
      .Input (in_v),
      .Acc   (acc_v),
      .Out   (out_v),
      .Zero  (zero_v),
      .Cout  (cout_v),
      .Busy  (busy_v),
      .Done  (done_v)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour straight from the opcode table, using integer arithmetic.
   task automatic model(input int o, input int a, input int b);
      int c, d;
      c = m_cout;
      case (o)
         0:  m_out = a;
         1:  m_out = b;
         4:  m_out = (a * 2) % MOD;
         5:  m_out = a / 2;
         6, 7: begin
            d = a + b + ((o == 7) ? c : 0);
            m_out  = d % MOD;
            m_cout = (d >= MOD) ? 1 : 0;
         end
         8, 9: begin
            d = a - b - ((o == 9) ? c : 0);
            m_cout = (d < 0) ? 1 : 0;
            m_out  = (d + 2 * MOD) % MOD;
         end
         10, 11: m_out = b;
         12: m_out = (b < a) ? 1 : 0;
         13: m_out = a % 2;
         14: m_out = a / (MOD / 2);
`ifdef SEQ_ALU_MUL_EN
         15: begin
            d = a * b;
            m_out  = d % MOD;
            m_cout = (d >= MOD) ? 1 : 0;
         end
`endif
         default: m_out = 0;
      endcase
   endtask

   task automatic check_result(input string tag);
      check({tag, " out"},  out_v,  32'(m_out));
      check({tag, " zero"}, zero_v, (m_out == 0) ? 1 : 0);
      check({tag, " cout"}, cout_v, 32'(m_cout));
   endtask

   task automatic do_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      op = o; in_v = a; acc_v = b; start = 1'b1;
      model(int'(o), int'(a), int'(b));
      cycle();
      check($sformatf("op%0h done", o), done_v, 1);
      check($sformatf("op%0h busy", o), busy_v, 0);
      check_result($sformatf("op%0h", o));
   endtask

   task automatic idle();
      int held;
      held = m_out;
      start = 1'b0;
      op = 4'($urandom);
      in_v = W'($urandom);
      cycle();
      check("idle done", done_v, 0);
      check("idle out", out_v, 32'(held));
   endtask

`ifdef SEQ_ALU_MUL_EN
   task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      op = OP_MUL; in_v = a; acc_v = b; start = 1'b1;
      cycle();
      // Requests during the multiply must be dropped.
      op = 4'($urandom); in_v = W'($urandom); acc_v = W'($urandom);
      check("mul busy0", busy_v, 1);
      check("mul nodone0", done_v, 0);
      for (int k = 1; k < W; k++) begin
         if (k == W - 1) start = 1'b0;
         cycle();
         check($sformatf("mul busy%0d", k), busy_v, 1);
         check($sformatf("mul nodone%0d", k), done_v, 0);
      end
      model(15, int'(a), int'(b));
      cycle();
      check("mul done", done_v, 1);
      check("mul busy end", busy_v, 0);
      check_result("mul");
   endtask
`endif

   initial begin
      rst = 1'b1;
      cycle();
      cycle();
      check("rst out", out_v, 0);
      check("rst zero", zero_v, 1);
      check("rst cout", cout_v, 0);
      check("rst busy", busy_v, 0);
      check("rst done", done_v, 0);
      rst = 1'b0;
      idle();

      do_op(OP_ADD, 8'hF0, 8'h20);
      do_op(OP_ADC, 8'h01, 8'h01);
      do_op(OP_SUB, 8'h05, 8'h05);
      do_op(OP_SUB, 8'h00, 8'h01);
      do_op(OP_SBC, 8'h00, 8'h00);
      idle();

      for (int i = 1; i <= 4; i++) do_op(OP_LD, W'(i), 8'h00);
      idle();

      do_op(OP_ADD, 8'hFF, 8'h01);
`ifdef SEQ_ALU_MUL_EN
      do_mul(8'h10, 8'h11);
      do_mul(8'h0F, 8'h0F);
      // Reset three cycles into a multiply aborts it without a completion pulse.
      op = OP_MUL; in_v = 8'h33; acc_v = 8'h44; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      m_out = 0; m_cout = 0;
      check("abort busy", busy_v, 0);
      check("abort done", done_v, 0);
      check_result("abort");
      for (int k = 0; k < W + 2; k++) begin
         cycle();
         check("abort nodone", done_v, 0);
      end
`else
      do_op(OP_MUL, 8'h10, 8'h11);
      do_op(OP_SUB, 8'h00, 8'h01);
      do_op(OP_MUL, 8'hFF, 8'hFF);
      // Reset also clears a completed non-zero result and a set carry.
      do_op(OP_ADD, 8'hF0, 8'h20);
      start = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      m_out = 0; m_cout = 0;
      check("rst2 done", done_v, 0);
      check_result("rst2");
`endif

      for (int i = 0; i < 300; i++) begin
         logic [3:0]   ro;
         logic [W-1:0] ra, rb;
         ro = 4'($urandom_range(0, 15));
         ra = W'($urandom);
         rb = W'($urandom);
`ifdef SEQ_ALU_MUL_EN
         if (ro == OP_MUL) do_mul(ra, rb);
         else              do_op(ro, ra, rb);
`else
         do_op(ro, ra, rb);
`endif
         if ($urandom_range(0, 3) == 0) idle();
      end
      start = 1'b0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
